// File: rtl/key_stream_reader.sv
// key_stream_reader: loads two key vectors M and N, then streams M[row] ^ N[col]
// in row-major order over a valid/ready interface, replayable on each start.
module key_stream_reader #(
    parameter int W     = 32,
    parameter int DEPTH = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [W-1:0] load_data,
    input  logic         start,
    output logic         key_valid,
    input  logic         key_ready,
    output logic [W-1:0] key_data,
    output logic         key_last,
    output logic         loaded,
    output logic         busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]     LOAD_LAST = '1;
    localparam logic [2*AW-1:0] IDX_LAST  = '1;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_IDLE,
        ST_STREAM
    } state_t;

    state_t          state_q, state_d;
    logic [AW:0]     load_cnt_q, load_cnt_d;
    logic [AW-1:0]   row_q, row_d;
    logic [AW-1:0]   col_q, col_d;
    logic            key_valid_q, key_valid_d;
    logic [W-1:0]    key_data_q, key_data_d;
    logic            key_last_q, key_last_d;

    logic [W-1:0]    m_mem [DEPTH];
    logic [W-1:0]    n_mem [DEPTH];

    logic            load_fire;
    logic [2*AW-1:0] idx_next;
    logic [AW-1:0]   next_row;
    logic [AW-1:0]   next_col;

    // A load word is taken only in LOAD, and never in a cycle that is being cleared or reset.
    assign load_fire = (state_q == ST_LOAD) && load_valid && rst_n && !clear;

    // Row and col form one flat word index; incrementing it gives the row-major successor.
    assign idx_next = {row_q, col_q} + (2*AW)'(1);
    assign next_row = idx_next[2*AW-1:AW];
    assign next_col = idx_next[AW-1:0];

    // Buffer writes: first DEPTH transfers go to M, the next DEPTH to N; contents survive clear.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            if (load_cnt_q[AW]) begin
                n_mem[load_cnt_q[AW-1:0]] <= load_data;
            end else begin
                m_mem[load_cnt_q[AW-1:0]] <= load_data;
            end
        end
    end

    // Next-state logic for the LOAD/IDLE/STREAM controller and its registered outputs.
    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        row_d       = row_q;
        col_d       = col_q;
        key_valid_d = key_valid_q;
        key_data_d  = key_data_q;
        key_last_d  = key_last_q;

        case (state_q)
            ST_LOAD: begin
                if (load_valid) begin
                    load_cnt_d = load_cnt_q + (AW+1)'(1);
                    if (load_cnt_q == LOAD_LAST) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_STREAM;
                    row_d       = '0;
                    col_d       = '0;
                    key_valid_d = 1'b1;
                    key_data_d  = m_mem[0] ^ n_mem[0];
                    key_last_d  = 1'b0;
                end
            end
            ST_STREAM: begin
                if (key_ready) begin
                    if (key_last_q) begin
                        state_d     = ST_IDLE;
                        key_valid_d = 1'b0;
                        key_last_d  = 1'b0;
                    end else begin
                        row_d      = next_row;
                        col_d      = next_col;
                        key_data_d = m_mem[next_row] ^ n_mem[next_col];
                        key_last_d = (idx_next == IDX_LAST);
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase

        if (clear) begin
            state_d     = ST_LOAD;
            load_cnt_d  = '0;
            row_d       = '0;
            col_d       = '0;
            key_valid_d = 1'b0;
            key_last_d  = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            load_cnt_q  <= '0;
            row_q       <= '0;
            col_q       <= '0;
            key_valid_q <= 1'b0;
            key_data_q  <= '0;
            key_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            row_q       <= row_d;
            col_q       <= col_d;
            key_valid_q <= key_valid_d;
            key_data_q  <= key_data_d;
            key_last_q  <= key_last_d;
        end
    end

    assign load_ready = (state_q == ST_LOAD);
    assign loaded     = (state_q != ST_LOAD);
    assign busy       = (state_q == ST_STREAM);
    assign key_valid  = key_valid_q;
    assign key_data   = key_data_q;
    assign key_last   = key_last_q;

endmodule

// File: tb/tb_key_stream_reader.sv
// Directed bench for key_stream_reader, using a reduced DEPTH so each pass is short.
module tb_key_stream_reader;

    localparam int W     = 32;
    localparam int DEPTH = 16;
    localparam int WORDS = DEPTH * DEPTH;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clear;
    logic         load_valid;
    logic         load_ready;
    logic [W-1:0] load_data;
    logic         start;
    logic         key_valid;
    logic         key_ready;
    logic [W-1:0] key_data;
    logic         key_last;
    logic         loaded;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] got   [WORDS];
    logic [W-1:0] pass1 [WORDS];

    key_stream_reader #(.W(W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .start      (start),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_data   (key_data),
        .key_last   (key_last),
        .loaded     (loaded),
        .busy       (busy)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Pattern 1: M[i] = i, N[j] = j << 8.  Pattern 2: M[i] = 0xA5A50000 + i, N[j] = 3*j.
    function automatic logic [W-1:0] loadWord(input int pat, input int i);
        int j;
        j = i - DEPTH;
        if (pat == 1) return (i < DEPTH) ? W'(i) : W'(j << 8);
        else          return (i < DEPTH) ? (32'hA5A5_0000 + W'(i)) : W'(3 * j);
    endfunction

    function automatic logic [W-1:0] expWord(input int pat, input int k);
        int r, c;
        r = k / DEPTH;
        c = k % DEPTH;
        if (pat == 1) return W'(r) ^ W'(c << 8);
        else          return (32'hA5A5_0000 + W'(r)) ^ W'(3 * c);
    endfunction

    task automatic applyStimulus(input int pat, input int n);
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_data  = loadWord(pat, i);
            if (i == 2*DEPTH-1) checkOutput("loaded_before_last", loaded, 0);
            tick();
        end
        load_valid = 1'b0;
        load_data  = '0;
    endtask

    task automatic startPass();
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("busy_after_start", busy, 1);
        checkOutput("valid_after_start", key_valid, 1);
    endtask

    task automatic runPass(input int pat, input int stall_at, input int stall_cycles, input int inject_at);
        int  k      = 0;
        int  cycles = 0;
        bit  done   = 0;
        key_ready = 1'b1;
        while (!done && cycles < WORDS + stall_cycles + 10) begin
            if (key_valid) begin
                if (k == stall_at && stall_cycles > 0) begin
                    key_ready = 1'b0;
                    for (int s = 0; s < stall_cycles; s++) begin
                        tick();
                        cycles++;
                        checkOutput("stall_valid", key_valid, 1);
                        checkOutput("stall_data", key_data, expWord(pat, k));
                    end
                    key_ready = 1'b1;
                end
                checkOutput("key_data", key_data, expWord(pat, k));
                checkOutput("key_last", key_last, (k == WORDS-1));
                got[k] = key_data;
                if (key_last) done = 1;
                k++;
            end
            if (k - 1 == inject_at) begin
                load_valid = 1'b1;
                load_data  = '1;
                start      = 1'b1;
            end
            tick();
            cycles++;
            load_valid = 1'b0;
            load_data  = '0;
            start      = 1'b0;
        end
        checkOutput("pass_done", done, 1);
        checkOutput("word_count", k, WORDS);
        checkOutput("pass_cycles", cycles, WORDS + stall_cycles);
        checkOutput("valid_after_last", key_valid, 0);
        checkOutput("busy_after_last", busy, 0);
        checkOutput("loaded_after_last", loaded, 1);
    endtask

    initial begin
        rst_n      = 1'b0;
        clear      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        start      = 1'b0;
        key_ready  = 1'b0;
        tick();
        tick();
        checkOutput("rst_valid", key_valid, 0);
        checkOutput("rst_data", key_data, 0);
        checkOutput("rst_last", key_last, 0);
        checkOutput("rst_loaded", loaded, 0);
        checkOutput("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();
        checkOutput("load_ready_after_rst", load_ready, 1);

        $display("[TB] start pulse during LOAD is ignored");
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("start_in_load_ready", load_ready, 1);
        checkOutput("start_in_load_busy", busy, 0);
        checkOutput("start_in_load_valid", key_valid, 0);

        applyStimulus(1, 2*DEPTH);
        checkOutput("loaded_after_load", loaded, 1);
        checkOutput("load_ready_after_load", load_ready, 0);
        checkOutput("busy_after_load", busy, 0);

        load_valid = 1'b1;
        load_data  = '1;
        tick();
        load_valid = 1'b0;
        load_data  = '0;

        $display("[TB] first pass with a 5-cycle stall at word 1");
        startPass();
        runPass(1, 1, 5, -1);
        checkOutput("word0", got[0], 32'h0);
        checkOutput("word1", got[1], 32'h100);
        checkOutput("word18", got[18], 32'h201);
        checkOutput("word_last", got[WORDS-1], 32'hF0F);
        for (int i = 0; i < WORDS; i++) pass1[i] = got[i];

        $display("[TB] back-to-back replay with load/start injected mid-stream");
        startPass();
        runPass(1, -1, 0, 40);
        for (int i = 0; i < WORDS; i++) checkOutput("replay", got[i], pass1[i]);

        $display("[TB] clear and start together in IDLE");
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        checkOutput("clr_start_ready", load_ready, 1);
        checkOutput("clr_start_busy", busy, 0);
        checkOutput("clr_start_loaded", loaded, 0);
        checkOutput("clr_start_valid", key_valid, 0);

        $display("[TB] clear at word 100 of a pass");
        applyStimulus(1, 2*DEPTH);
        startPass();
        key_ready = 1'b1;
        for (int k = 0; k < 100; k++) tick();
        checkOutput("pre_clear_data", key_data, expWord(1, 100));
        clear      = 1'b1;
        load_valid = 1'b1;
        load_data  = '1;
        tick();
        clear      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        checkOutput("clear_valid", key_valid, 0);
        checkOutput("clear_last", key_last, 0);
        checkOutput("clear_ready", load_ready, 1);
        checkOutput("clear_loaded", loaded, 0);
        checkOutput("clear_busy", busy, 0);
        applyStimulus(1, 2*DEPTH);
        startPass();
        runPass(1, -1, 0, -1);

        $display("[TB] reset mid-load then reload a new pattern");
        applyStimulus(2, 20);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("midload_rst_ready", load_ready, 1);
        checkOutput("midload_rst_loaded", loaded, 0);
        checkOutput("midload_rst_data", key_data, 0);
        applyStimulus(2, 2*DEPTH);
        checkOutput("reload_loaded", loaded, 1);
        startPass();
        runPass(2, -1, 0, -1);
        checkOutput("p2_word0", got[0], 32'hA5A5_0000);
        checkOutput("p2_word18", got[18], 32'hA5A5_0007);
        checkOutput("p2_word_last", got[WORDS-1], 32'hA5A5_0022);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
